// File: rtl/fma16_pkg.sv
// Shared types, constants and rounding helpers for the fma16 normalize/round back end.
package fma16_pkg;

    typedef enum logic [1:0] {
        RZ  = 2'b00,
        RNE = 2'b01,
        RDN = 2'b10,
        RUP = 2'b11
    } roundmode_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } flags_t;

    localparam int BIAS = 15;
    localparam int NF   = 10;
    localparam int EMAX = 30;
    localparam logic [14:0] MAXNORM = 15'h7BFF;
    localparam logic [14:0] INF     = 15'h7C00;

    function automatic logic round_inc(input roundmode_t rm, input logic sign,
                                       input logic g, input logic s, input logic lsb);
        case (rm)
            RNE:     return g & (s | lsb);
            RDN:     return (g | s) & sign;
            RUP:     return (g | s) & ~sign;
            default: return 1'b0;
        endcase
    endfunction

    // True when an overflowing result must become infinity rather than maxnorm.
    function automatic logic round_away(input roundmode_t rm, input logic sign);
        return (rm == RNE) | ((rm == RUP) & ~sign) | ((rm == RDN) & sign);
    endfunction

endpackage

// File: rtl/fma16_normround_if.sv
// Handshake bundle between the fma16 adder stage, the normalize/round back end and its consumer.
interface fma16_normround_if #(
    parameter int SM_W = 34,
    parameter int SE_W = 7
);
    logic            in_valid;
    logic            in_ready;
    logic [SM_W-1:0] Sm;
    logic [SE_W-1:0] Se;
    logic            Ss;
    logic            ASticky;
    logic [1:0]      roundmode;
    logic            special;
    logic [15:0]     special_val;
    logic [3:0]      special_flags;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     result;
    logic [3:0]      flags;

    modport master (
        output in_valid, Sm, Se, Ss, ASticky, roundmode, special, special_val, special_flags,
        output out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, Sm, Se, Ss, ASticky, roundmode, special, special_val, special_flags,
        input  out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fma16_lzc.sv
// Leading-one index of a W-bit vector plus an all-zero flag.
module fma16_lzc #(
    parameter int W  = 34,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  v,
    output logic [IW-1:0] idx,
    output logic          zero
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) idx = IW'(i);
        end
    end

    assign zero = (v == '0);
endmodule

// File: rtl/fma16_normround.sv
// Two-stage normalize/round/pack of the fma16 magnitude sum into binary16 with flags.
// Gradual underflow is built only when FMA16_SUBNORM_EN is defined; otherwise tiny results flush to zero.
module fma16_normround
    import fma16_pkg::*;
#(
    parameter int SM_W  = 34,
    parameter int SE_W  = 7,
    parameter int BINPT = 21
) (
    input logic clk,
    input logic reset,
    fma16_normround_if.slave bus
);
    localparam int LW = $clog2(SM_W);
    localparam int EW = SE_W + 2;
    localparam int XW = SM_W + 12;
    localparam int PW = EW + NF;

    logic [LW-1:0]   lz_idx;
    logic            lz_zero;
    logic [EW-1:0]   e_next;

    logic            s1_valid, s2_valid, s1_adv, s2_adv;
    logic [SM_W-1:0] s1_sm;
    logic [LW-1:0]   s1_lidx;
    logic [EW-1:0]   s1_e;
    logic            s1_ss, s1_ast, s1_zero, s1_special;
    logic [1:0]      s1_rm;
    logic [15:0]     s1_sval;
    logic [3:0]      s1_sflags;
    logic [15:0]     s2_result, st2_result;
    flags_t          s2_flags, st2_flags;

    fma16_lzc #(.W(SM_W)) u_lzc (.v(bus.Sm), .idx(lz_idx), .zero(lz_zero));

    assign e_next = {{(EW-SE_W){bus.Se[SE_W-1]}}, bus.Se}
                  + {{(EW-LW){1'b0}}, lz_idx} - EW'(BINPT);

    // A stage takes new data when it is empty or its content moves on this cycle;
    // a beat transfers on any edge where valid and ready are both high.
    assign s2_adv       = ~s2_valid | bus.out_ready;
    assign s1_adv       = ~s1_valid | s2_adv;
    assign bus.in_ready = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_result;
    assign bus.flags     = s2_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sm      <= bus.Sm;
                    s1_lidx    <= lz_idx;
                    s1_e       <= e_next;
                    s1_ss      <= bus.Ss;
                    s1_ast     <= bus.ASticky;
                    s1_rm      <= bus.roundmode;
                    s1_zero    <= lz_zero;
                    s1_special <= bus.special;
                    s1_sval    <= bus.special_val;
                    s1_sflags  <= bus.special_flags;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= st2_result;
                    s2_flags  <= st2_flags;
                end
            end
        end
    end

    logic [LW-1:0]   sh_l;
    logic [SM_W-1:0] aligned;
    logic [XW-1:0]   ext, shifted;
    logic            tiny, hidden, g, s, inc, ovf;
    logic [NF-1:0]   frac;
    logic [EW-1:0]   exp_base, final_exp;
    logic [PW-1:0]   pack;

    // Leading one lands on the hidden bit at the top of ext; 12 spare bits catch the subnormal shift-out.
    assign sh_l    = LW'(SM_W - 1) - s1_lidx;
    assign aligned = s1_sm << sh_l;
    assign ext     = {aligned, 12'b0};
    assign tiny    = s1_zero | s1_e[EW-1] | (s1_e == '0);

`ifdef FMA16_SUBNORM_EN
    logic [EW-1:0] neg_e;
    logic [3:0]    sub_sh;
    assign neg_e   = '0 - s1_e;
    assign sub_sh  = (neg_e >= EW'(11)) ? 4'd12 : 4'(neg_e + EW'(1));
    assign shifted = tiny ? (ext >> sub_sh) : ext;
`else
    assign shifted = ext;
`endif

    assign hidden = shifted[XW-1];
    assign frac   = shifted[XW-2 -: NF];
    assign g      = shifted[XW-2-NF];
    assign s      = (|shifted[XW-3-NF:0]) | s1_ast;
    assign inc    = round_inc(roundmode_t'(s1_rm), s1_ss, g, s, frac[0]);

    // Hidden bit adds one to the exponent field, so a normal uses E-1 and a carry-out ripples naturally.
    assign exp_base  = tiny ? '0 : s1_e - EW'(1);
    assign pack      = {exp_base, {NF{1'b0}}} + PW'({hidden, frac}) + PW'(inc);
    assign final_exp = pack[PW-1:NF];
    assign ovf       = final_exp > EW'(EMAX);

    always_comb begin
        st2_result          = {s1_ss, pack[14:0]};
        st2_flags           = '0;
        st2_flags.underflow = tiny & (g | s);
        st2_flags.inexact   = g | s;
        if (s1_special) begin
            st2_result = s1_sval;
            st2_flags  = flags_t'(s1_sflags);
        end else if (s1_zero & ~s1_ast) begin
            st2_result = {s1_ss, 15'h0000};
            st2_flags  = '0;
`ifndef FMA16_SUBNORM_EN
        end else if (tiny) begin
            st2_result          = {s1_ss, 15'h0000};
            st2_flags           = '0;
            st2_flags.underflow = 1'b1;
            st2_flags.inexact   = 1'b1;
`endif
        end else if (ovf) begin
            st2_result         = {s1_ss, round_away(roundmode_t'(s1_rm), s1_ss) ? INF : MAXNORM};
            st2_flags          = '0;
            st2_flags.overflow = 1'b1;
            st2_flags.inexact  = 1'b1;
        end
    end
endmodule
